usb_clock_div_prog: RTL and testbench

Runtime-programmable integer clock divider for the USB 3.0 PHY serialiser clock path. It generalises the fixed divide-by-10 bit-clock divider with the following features:
- parametrised counter width
- divide ratio loadable at runtime and applied glitch-free at a period boundary
- enable with graceful stop at the end of a period
- one-cycle period strobe for downstream parallel-load logic

---
 rtl/usb_clock_div_prog.sv | 135 +++++++++++++
 tb/tb_usb_clock_div_prog.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_clock_div_prog.sv
// Runtime-programmable integer clock divider for the USB 3.0 serialiser bit-clock path.
// Optional build macro USB_CLKDIV_DUTY50_EN adds a negedge stage giving 50% duty for odd ratios.
module usb_clock_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [CNT_W-1:0] DIV_VAL,
    input  logic             DIV_LOAD,
    output logic             DIV_ACK,
    output logic [CNT_W-1:0] ACTIVE_DIV,
    output logic             BITCLK_OUT,
    output logic             TICK,
    output logic             RUNNING
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             bitclk_q, bitclk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             running_q, running_d;

    logic             boundary;
    logic             apply;
    logic [CNT_W-1:0] high_cnt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        boundary = (state_q != ST_IDLE) && (cnt_q == (active_q - ONE));
        // A pending ratio only takes effect between periods, so the waveform never glitches.
        apply    = pend_vld_q && ((state_q == ST_IDLE) || boundary);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (EN) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!EN) state_d = ST_STOP;
                cnt_d = boundary ? '0 : (cnt_q + ONE);
            end
            ST_STOP: begin
                if (EN)            state_d = ST_RUN;
                else if (boundary) state_d = ST_IDLE;
                cnt_d = boundary ? '0 : (cnt_q + ONE);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (apply) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end

        // A load in the same cycle as an apply stays pending for the following boundary.
        if (DIV_LOAD) begin
            pend_d     = (DIV_VAL < MIN_DIV) ? MIN_DIV : DIV_VAL;
            pend_vld_d = 1'b1;
        end

        // Outputs are precomputed from next-state values so they line up with cnt_q.
        running_d = (state_d != ST_IDLE);
        high_cnt  = active_d - (active_d >> 1);
        bitclk_d  = running_d && (cnt_d < high_cnt);
        tick_d    = running_d && (cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            active_q   <= DEF_DIV;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bitclk_q   <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bitclk_q   <= bitclk_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            running_q  <= running_d;
        end
    end

`ifdef USB_CLKDIV_DUTY50_EN
    logic bitclk_neg_q;

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) bitclk_neg_q <= 1'b0;
        else      bitclk_neg_q <= bitclk_q;
    end

    // For odd ratios the rising edge is delayed half a cycle, trimming high time to N/2.
    assign BITCLK_OUT = active_q[0] ? (bitclk_q & bitclk_neg_q) : bitclk_q;
`else
    assign BITCLK_OUT = bitclk_q;
`endif

    assign TICK       = tick_q;
    assign DIV_ACK    = ack_q;
    assign ACTIVE_DIV = active_q;
    assign RUNNING    = running_q;

endmodule

// File: tb/tb_usb_clock_div_prog.sv
// Directed, table-driven bench for usb_clock_div_prog (default build, 8-bit ratio, reset ratio 10).
module tb_usb_clock_div_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_ack;
  logic [7:0] active_div;
  logic       bitclk_out;
  logic       tick;
  logic       running;

  int checks = 0;
  int errors = 0;

  usb_clock_div_prog #(.CNT_W(8), .DEFAULT_DIV(10)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .EN         (en),
    .DIV_VAL    (div_val),
    .DIV_LOAD   (div_load),
    .DIV_ACK    (div_ack),
    .ACTIVE_DIV (active_div),
    .BITCLK_OUT (bitclk_out),
    .TICK       (tick),
    .RUNNING    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] val;
    logic       b;
    logic       t;
    logic       a;
    logic [7:0] act;
    logic       r;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic ld, input logic [7:0] v,
                     input logic b, input logic t, input logic a,
                     input logic [7:0] act, input logic r);
    vec_t x;
    x.en = e; x.ld = ld; x.val = v; x.b = b; x.t = t; x.a = a; x.act = act; x.r = r;
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic eb, input logic et, input logic ea,
                     input logic [7:0] eact, input logic er);
    checks++;
    if (bitclk_out !== eb || tick !== et || div_ack !== ea || active_div !== eact || running !== er) begin
      errors++;
      $display("FAIL %s: got bclk=%0b tick=%0b ack=%0b act=%0d run=%0b, want bclk=%0b tick=%0b ack=%0b act=%0d run=%0b",
               nm, bitclk_out, tick, div_ack, active_div, running, eb, et, ea, eact, er);
    end
  endtask

  initial begin
    int period;
    int high;
    bit found;

    // N=10 from reset: 5 high / 5 low, tick at cnt 0
    add(1,0,0, 1,1,0,10,1);
    repeat (4) add(1,0,0, 1,0,0,10,1);
    repeat (5) add(1,0,0, 0,0,0,10,1);
    add(1,0,0, 1,1,0,10,1);
    repeat (2) add(1,0,0, 1,0,0,10,1);
    // load 4 mid-period, current 10-cycle period completes
    add(1,1,4, 1,0,0,10,1);
    add(1,0,0, 1,0,0,10,1);
    repeat (5) add(1,0,0, 0,0,0,10,1);
    add(1,0,0, 1,1,1,4,1);
    add(1,0,0, 1,0,0,4,1);
    repeat (2) add(1,0,0, 0,0,0,4,1);
    add(1,0,0, 1,1,0,4,1);
    // loads 6 then 8 in one period, last wins, one ack
    add(1,1,6, 1,0,0,4,1);
    add(1,1,8, 0,0,0,4,1);
    add(1,0,0, 0,0,0,4,1);
    add(1,0,0, 1,1,1,8,1);
    repeat (3) add(1,0,0, 1,0,0,8,1);
    repeat (4) add(1,0,0, 0,0,0,8,1);
    add(1,0,0, 1,1,0,8,1);
    // clamp: 0 -> 2, then 1 -> 2
    add(1,1,0, 1,0,0,8,1);
    repeat (2) add(1,0,0, 1,0,0,8,1);
    repeat (4) add(1,0,0, 0,0,0,8,1);
    add(1,0,0, 1,1,1,2,1);
    add(1,1,1, 0,0,0,2,1);
    add(1,0,0, 1,1,1,2,1);
    add(1,0,0, 0,0,0,2,1);
    add(1,0,0, 1,1,0,2,1);
    // pending 3 applied at a boundary that also loads 7; 7 waits one period
    add(1,1,3, 0,0,0,2,1);
    add(1,1,7, 1,1,1,3,1);
    add(1,0,0, 1,0,0,3,1);
    add(1,0,0, 0,0,0,3,1);
    add(1,0,0, 1,1,1,7,1);
    // N=7, EN dropped at cnt 2: period finishes, then idle
    repeat (2) add(1,0,0, 1,0,0,7,1);
    add(0,0,0, 1,0,0,7,1);
    repeat (3) add(0,0,0, 0,0,0,7,1);
    repeat (2) add(0,0,0, 0,0,0,7,0);
    // restart, stop, re-raise EN at cnt 5: no gap
    add(1,0,0, 1,1,0,7,1);
    repeat (3) add(0,0,0, 1,0,0,7,1);
    repeat (2) add(0,0,0, 0,0,0,7,1);
    add(1,0,0, 0,0,0,7,1);
    add(1,0,0, 1,1,0,7,1);
    add(1,0,0, 1,0,0,7,1);
    // load during STOP: applied as block enters idle
    add(0,0,0, 1,0,0,7,1);
    add(0,1,4, 1,0,0,7,1);
    repeat (3) add(0,0,0, 0,0,0,7,1);
    add(0,0,0, 0,0,1,4,0);
    add(0,0,0, 0,0,0,4,0);
    // load in idle: applied the next cycle
    add(0,1,3, 0,0,0,4,0);
    add(0,0,0, 0,0,1,3,0);
    add(0,0,0, 0,0,0,3,0);
    // load at a boundary with nothing pending waits a full period
    add(1,0,0, 1,1,0,3,1);
    add(1,0,0, 1,0,0,3,1);
    add(1,0,0, 0,0,0,3,1);
    add(1,1,5, 1,1,0,3,1);
    add(1,0,0, 1,0,0,3,1);
    add(1,0,0, 0,0,0,3,1);
    add(1,0,0, 1,1,1,5,1);
    add(1,0,0, 1,0,0,5,1);

    // clock/reset
    #1 rst_n = 1'b0;
    #1 chk("reset_state", 0,0,0,10,0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en;
      div_load = vecs[i].ld;
      div_val = vecs[i].val;
      step();
      chk($sformatf("row%0d", i), vecs[i].b, vecs[i].t, vecs[i].a, vecs[i].act, vecs[i].r);
    end
    div_load = 1'b0;

    // reset mid-period with a load pending
    en = 1'b1; div_load = 1'b1; div_val = 8'd9;
    step();
    div_load = 1'b0;
    chk("pre_reset", 1,0,0,5,1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0,0,0,10,0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pending_lost", 0,0,0,10,0);
    end

    // restart at the reset ratio and measure one full period
    en = 1'b1;
    step();
    chk("restart", 1,1,0,10,1);
    period = 1;
    high = 1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (tick) found = 1'b1;
      else begin
        period++;
        if (bitclk_out) high++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_timeout: no tick within 40 cycles, want tick after 10");
    end else if (period != 10 || high != 5) begin
      errors++;
      $display("FAIL period_measure: got period=%0d high=%0d, want period=10 high=5", period, high);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
